// File: rtl/kfps2kb_xt_port_controller.sv
// XT keyboard port sequencer for the KFPS2KB decoder.
// It queues the decoded codes, hands them to the host one IRQ at a time, and emulates the soft reset.
module kfps2kb_xt_port_controller #(
    parameter int          fifo_addr_width   = 3,
    parameter logic [15:0] gap_cycles        = 16'd64,
    parameter logic [15:0] reset_hold_cycles = 16'd2000,
    parameter logic [15:0] self_test_cycles  = 16'd5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kb_irq,
    input  logic [7:0] kb_keycode,
    output logic       kb_clear,
    input  logic       port_b_clear,
    input  logic       kbd_clock_low,
    output logic       irq,
    output logic [7:0] keycode,
    output logic       overrun
);

    localparam int AW    = fifo_addr_width;
    localparam int CW    = fifo_addr_width + 1;
    localparam int DEPTH = 2 ** fifo_addr_width;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESENT  = 3'd1;
    localparam logic [2:0] S_ACK      = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_RST_HOLD = 3'd4;
    localparam logic [2:0] S_SELFTEST = 3'd5;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pending_q, overrun_q, kb_clear_q, pbc_q;
    logic          irq_q, irq_d;
    logic [7:0]    keycode_q, keycode_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic [15:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]   st_cnt_q, st_cnt_d;

    logic       full, empty, take, ing_push, ing_drop, ff_push, push, pop;
    logic       hold_hit, st_done, flush;
    logic [7:0] push_data;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign take      = kb_irq && !kb_clear_q;
    assign ing_push  = take && !kbd_clock_low && !full;
    assign ing_drop  = take && !kbd_clock_low && full;
    assign ff_push   = pending_q && !full && !ing_push && !kb_clear_q;
    assign push      = ing_push || ff_push;
    assign push_data = ing_push ? kb_keycode : 8'hFF;

    // A sustained inhibit is a reset request unless one is already being served.
    assign hold_hit = kbd_clock_low && (state_q != S_RST_HOLD) &&
                      (hold_cnt_q == reset_hold_cycles - 16'd1);
    assign st_done  = (state_q == S_SELFTEST) && !kbd_clock_low &&
                      (st_cnt_q == self_test_cycles - 16'd1);
    assign flush    = hold_hit || (state_q == S_RST_HOLD) ||
                      ((state_q == S_SELFTEST) && kbd_clock_low);
    assign pop      = (state_q == S_PRESENT) && port_b_clear && !pbc_q && !hold_hit;

    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        keycode_d = keycode_q;
        gap_cnt_d = gap_cnt_q;
        st_cnt_d  = st_cnt_q;
        if (!kbd_clock_low)
            hold_cnt_d = 16'd0;
        else if (hold_cnt_q != reset_hold_cycles)
            hold_cnt_d = hold_cnt_q + 16'd1;
        else
            hold_cnt_d = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!empty && !port_b_clear) begin
                    state_d   = S_PRESENT;
                    irq_d     = 1'b1;
                    keycode_d = mem_q[rd_ptr_q];
                end
            end
            S_PRESENT: begin
                if (pop) begin
                    state_d   = S_ACK;
                    irq_d     = 1'b0;
                    keycode_d = 8'h00;
                end
            end
            S_ACK: begin
                if (!port_b_clear) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 16'd0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == gap_cycles - 16'd1)
                    state_d = S_IDLE;
                else
                    gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_RST_HOLD: begin
                if (!kbd_clock_low) begin
                    state_d  = S_SELFTEST;
                    st_cnt_d = 16'd0;
                end
            end
            S_SELFTEST: begin
                if (kbd_clock_low) begin
                    state_d    = S_RST_HOLD;
                    hold_cnt_d = 16'd0;
                end else if (st_done) begin
                    state_d = S_IDLE;
                end else begin
                    st_cnt_d = st_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hold_hit) begin
            state_d   = S_RST_HOLD;
            irq_d     = 1'b0;
            keycode_d = 8'h00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            irq_q      <= 1'b0;
            keycode_q  <= 8'h00;
            kb_clear_q <= 1'b0;
            pbc_q      <= 1'b0;
            hold_cnt_q <= 16'd0;
            gap_cnt_q  <= 16'd0;
            st_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            keycode_q  <= keycode_d;
            kb_clear_q <= take;
            pbc_q      <= port_b_clear;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            st_cnt_q   <= st_cnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (st_done) begin
            // Self-test leaves only the 8'hAA completion code queued.
            wr_ptr_q  <= AW'(1);
            rd_ptr_q  <= '0;
            count_q   <= CW'(1);
            pending_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ing_drop) begin
                overrun_q <= 1'b1;
                pending_q <= 1'b1;
            end else if (ff_push) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (st_done)
            mem_q[0] <= 8'hAA;
        else if (push && !flush)
            mem_q[wr_ptr_q] <= push_data;
    end

    assign kb_clear = kb_clear_q;
    assign irq      = irq_q;
    assign keycode  = keycode_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_kfps2kb_xt_port_controller.sv
// Bench for the XT port sequencer: decoder and BIOS models with a queue of expected codes.
// Short timing parameters keep the reset and self-test scenarios quick.
module tb_kfps2kb_xt_port_controller;

    localparam logic [15:0] GAP  = 16'd12;
    localparam logic [15:0] HOLD = 16'd30;
    localparam logic [15:0] ST   = 16'd50;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       kb_irq = 1'b0;
    logic [7:0] kb_keycode = 8'h00;
    logic       port_b_clear = 1'b0;
    logic       kbd_clock_low = 1'b0;
    logic       kb_clear, irq, overrun;
    logic [7:0] keycode;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    kfps2kb_xt_port_controller #(
        .fifo_addr_width  (3),
        .gap_cycles       (GAP),
        .reset_hold_cycles(HOLD),
        .self_test_cycles (ST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .kb_irq       (kb_irq),
        .kb_keycode   (kb_keycode),
        .kb_clear     (kb_clear),
        .port_b_clear (port_b_clear),
        .kbd_clock_low(kbd_clock_low),
        .irq          (irq),
        .keycode      (keycode),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_code(input logic [7:0] c, input bit acc);
        int n = 0;
        kb_irq     = 1'b1;
        kb_keycode = c;
        if (acc)
            exp_q.push_back(c);
        do begin
            tick();
            n++;
        end while (!kb_clear && n < 8);
        check("kbclr", kb_clear, 1);
        kb_irq = 1'b0;
        tick();
        check("kbclr_1clk", kb_clear, 0);
    endtask

    task automatic expect_present(input string tag, input int max);
        int n = 0;
        logic [7:0] e;
        while (!irq && n < max) begin
            tick();
            n++;
        end
        check({tag, "_irq"}, irq, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_kc"}, keycode, e);
    endtask

    task automatic ack();
        port_b_clear = 1'b1;
        tick();
        check("ack_irq", irq, 0);
        check("ack_kc", keycode, 0);
        port_b_clear = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        check("rst_irq", irq, 0);
        check("rst_kc", keycode, 0);
        check("rst_kbclr", kb_clear, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b0;
        tick();

        // single code reaches the host within a few clocks
        kb_irq     = 1'b1;
        kb_keycode = 8'h1E;
        exp_q.push_back(8'h1E);
        tick();
        check("t1_kbclr", kb_clear, 1);
        kb_irq = 1'b0;
        tick();
        check("t1_kbclr_lo", kb_clear, 0);
        expect_present("t1", 1);

        // acknowledge with a second code waiting; measure the gap
        send_code(8'h2C, 1'b1);
        check("t2_hold_kc", keycode, 8'h1E);
        ack();
        n = 0;
        while (!irq && n < GAP + 8) begin
            tick();
            n++;
        end
        check("t2_gap_lat", n, GAP + 1);
        expect_present("t2", 1);
        ack();

        // nine codes into an eight-deep queue
        for (int i = 0; i < 9; i++)
            send_code(8'h10 + 8'(i), i < 8);
        exp_q.push_back(8'hFF);
        check("t3_ovr", overrun, 1);
        for (int i = 0; i < 9; i++) begin
            expect_present("t3", GAP + 10);
            ack();
        end
        repeat (GAP + 5) tick();
        check("t3_empty", irq, 0);
        check("t3_ovr_sticky", overrun, 1);

        // full keyboard reset flushes queued codes and returns AA
        send_code(8'h20, 1'b0);
        send_code(8'h21, 1'b0);
        kbd_clock_low = 1'b1;
        repeat (HOLD) tick();
        check("t4_irq", irq, 0);
        check("t4_kc", keycode, 0);
        check("t4_ovr", overrun, 0);
        kbd_clock_low = 1'b0;
        n = 0;
        while (!irq && n < ST + 10) begin
            tick();
            n++;
        end
        check("t4_lat", (n >= ST) && (n <= ST + 3), 1);
        exp_q.push_back(8'hAA);
        expect_present("t4", 1);
        check("t4_ovr2", overrun, 0);
        ack();

        // short inhibit keeps state; codes sent meanwhile are discarded
        send_code(8'h33, 1'b1);
        send_code(8'h34, 1'b1);
        expect_present("t5a", GAP + 10);
        kbd_clock_low = 1'b1;
        kb_irq        = 1'b1;
        kb_keycode    = 8'h44;
        tick();
        check("t5_inh_kbclr", kb_clear, 1);
        kb_irq = 1'b0;
        tick();
        check("t5_inh_kbclr_lo", kb_clear, 0);
        repeat (HOLD - 3) tick();
        kbd_clock_low = 1'b0;
        tick();
        check("t5_keep_irq", irq, 1);
        check("t5_keep_kc", keycode, 8'h33);
        ack();
        expect_present("t5b", GAP + 10);
        ack();
        repeat (GAP + 5) tick();
        check("t5_nopush", irq, 0);
        check("t5_ovr", overrun, 0);

        // port_b_clear already high holds off presentation
        port_b_clear = 1'b1;
        send_code(8'h66, 1'b1);
        repeat (5) tick();
        check("blk_irq", irq, 0);
        port_b_clear = 1'b0;
        expect_present("blk", 3);
        ack();

        // reset while presenting
        send_code(8'h55, 1'b0);
        n = 0;
        while (!irq && n < GAP + 10) begin
            tick();
            n++;
        end
        check("t6_pre_irq", irq, 1);
        reset = 1'b1;
        #1;
        check("t6a_irq", irq, 0);
        check("t6a_kc", keycode, 0);
        check("t6a_kbclr", kb_clear, 0);
        check("t6a_ovr", overrun, 0);
        tick();
        reset = 1'b0;
        repeat (GAP + 5) tick();
        check("t6a_empty", irq, 0);

        // reset while in self-test aborts the AA report
        kbd_clock_low = 1'b1;
        repeat (HOLD) tick();
        kbd_clock_low = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("t6b_irq", irq, 0);
        check("t6b_kc", keycode, 0);
        tick();
        reset = 1'b0;
        repeat (ST + 10) tick();
        check("t6b_noaa", irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
